// File: rtl/wb_arbiter_2m_if.sv
// wb_arbiter_2m_if: Wishbone classic bus bundle; master drives the request, slave returns ack/err/data.
interface wb_arbiter_2m_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, err);
    modport slave (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master Wishbone arbiter with fair contention and cyc-held ownership.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that aborts unacknowledged transactions.
module wb_arbiter_2m #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    wb_arbiter_2m_if.slave         m0,
    wb_arbiter_2m_if.slave         m1,
    wb_arbiter_2m_if.master        s,
    output logic [1:0]             grant_o
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t state, state_n;
    logic   last_grant, req0, req1, g0, g1, timeout;

    assign req0 = m0.cyc & m0.stb;
    assign req1 = m1.cyc & m1.stb;
    assign g0   = state == GNT0;
    assign g1   = state == GNT1;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..1023");
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [9:0] TO = 10'(TIMEOUT_CYCLES);
    logic [9:0] cnt;
    logic       owner_stb;
    assign owner_stb = g0 ? m0.stb : m1.stb;
    // an ack in the expiry cycle still completes the transfer normally
    assign timeout   = (g0 | g1) & (cnt == TO) & ~s.ack;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_n != state || s.ack)
            cnt <= '0;
        else if ((g0 | g1) && owner_stb)
            cnt <= cnt + 10'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_n;
            last_grant <= (g0 && state_n != GNT0) ? 1'b0 :
                          (g1 && state_n != GNT1) ? 1'b1 : last_grant;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (req0 & req1) ? (last_grant ? GNT0 : GNT1) :
                               req0 ? GNT0 : req1 ? GNT1 : IDLE;
            GNT0:    state_n = (~m0.cyc | timeout) ? IDLE : GNT0;
            GNT1:    state_n = (~m1.cyc | timeout) ? IDLE : GNT1;
            default: state_n = IDLE;
        endcase
    end

    // responses are suppressed while reset is asserted so nothing leaks mid-abort
    always_comb begin
        s.cyc    = g0 ? m0.cyc   : g1 ? m1.cyc   : 1'b0;
        s.stb    = g0 ? m0.stb   : g1 ? m1.stb   : 1'b0;
        s.we     = g0 ? m0.we    : g1 ? m1.we    : 1'b0;
        s.sel    = g0 ? m0.sel   : g1 ? m1.sel   : 4'h0;
        s.adr    = g0 ? m0.adr   : g1 ? m1.adr   : 32'h0;
        s.dat_w  = g0 ? m0.dat_w : g1 ? m1.dat_w : 32'h0;
        m0.ack   = g0 & s.ack & ~wb_rst_i;
        m1.ack   = g1 & s.ack & ~wb_rst_i;
        m0.err   = g0 & timeout & ~wb_rst_i;
        m1.err   = g1 & timeout & ~wb_rst_i;
        m0.dat_r = g0 ? s.dat_r : 32'h0;
        m1.dat_r = g1 ? s.dat_r : 32'h0;
        grant_o  = {g1, g0};
    end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed scenarios plus random traffic checked against a cycle-level ownership model.
module tb_wb_arbiter_2m;
    localparam int TO = 8;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] grant;
    always #5 clk = ~clk;

    wb_arbiter_2m_if m0_bus ();
    wb_arbiter_2m_if m1_bus ();
    wb_arbiter_2m_if s_bus ();

    wb_arbiter_2m #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus), .grant_o(grant)
    );

    logic        cyc [2], stb [2], we [2];
    logic [3:0]  sel [2];
    logic [31:0] adr [2], wdat [2];
    logic        s_ack;
    logic [31:0] s_dat;
    logic [31:0] adrs [3] = '{32'h3000_0000, 32'h3000_0004, 32'h3000_000C};
    int owner = -1, last = 1, wait_cnt = 0;
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic tmo();
`ifdef WB_ARB_TIMEOUT_EN
        return owner >= 0 && wait_cnt == TO && !s_ack;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive();
        m0_bus.cyc = cyc[0]; m0_bus.stb = stb[0]; m0_bus.we = we[0];
        m0_bus.sel = sel[0]; m0_bus.adr = adr[0]; m0_bus.dat_w = wdat[0];
        m1_bus.cyc = cyc[1]; m1_bus.stb = stb[1]; m1_bus.we = we[1];
        m1_bus.sel = sel[1]; m1_bus.adr = adr[1]; m1_bus.dat_w = wdat[1];
        s_bus.ack = s_ack; s_bus.dat_r = s_dat; s_bus.err = 1'b0;
    endtask

    task automatic settle();
        int o;
        logic [70:0] req;
        drive();
        #1;
        o = owner < 0 ? 0 : owner;
        req = owner < 0 ? 71'h0 : {cyc[o], stb[o], we[o], sel[o], adr[o], wdat[o]};
        chk("grant", grant, owner == 0 ? 2'b01 : owner == 1 ? 2'b10 : 2'b00);
        chk("s_req", {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.sel, s_bus.adr, s_bus.dat_w}, req);
        chk("m0_rsp", {m0_bus.ack, m0_bus.err, m0_bus.dat_r},
            {!rst && owner == 0 && s_ack, !rst && owner == 0 && tmo(), owner == 0 ? s_dat : 32'h0});
        chk("m1_rsp", {m1_bus.ack, m1_bus.err, m1_bus.dat_r},
            {!rst && owner == 1 && s_ack, !rst && owner == 1 && tmo(), owner == 1 ? s_dat : 32'h0});
    endtask

    task automatic tick();
        logic r0, r1;
        @(posedge clk);
        r0 = cyc[0] & stb[0];
        r1 = cyc[1] & stb[1];
        if (rst) begin
            owner = -1; last = 1; wait_cnt = 0;
        end else if (owner < 0) begin
            owner = (r0 && r1) ? 1 - last : r0 ? 0 : r1 ? 1 : -1;
        end else if (tmo() || !cyc[owner]) begin
            last = owner; owner = -1; wait_cnt = 0;
        end else if (s_ack) begin
            wait_cnt = 0;
        end else if (stb[owner]) begin
            wait_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        for (int n = 0; n < 2; n++) begin
            cyc[n] = 0; stb[n] = 0; we[n] = 0; sel[n] = 4'h0; adr[n] = 32'h0; wdat[n] = 32'h0;
        end
        s_ack = 0; s_dat = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1; settle(); tick(); rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        drive();
        @(negedge clk);
        tick();
        rst = 0;
        settle();
        chk("rst_state", {grant, s_bus.cyc, s_bus.stb, m0_bus.err, m1_bus.err}, 6'b0);
        tick();

        // single m0 read, slave acks two cycles after stb
        cyc[0] = 1; stb[0] = 1; sel[0] = 4'hF; adr[0] = 32'h3000_0008;
        settle(); chk("r29_idle", grant, 2'b00); tick();
        settle(); chk("r29_grant", {grant, s_bus.cyc, s_bus.stb}, 4'b0111); tick();
        settle(); tick();
        s_ack = 1; s_dat = 32'hE000_00FB;
        settle(); chk("r29_ack", {m0_bus.ack, m0_bus.dat_r, m1_bus.ack}, {1'b1, 32'hE000_00FB, 1'b0}); tick();
        idle(); settle(); tick(); settle(); tick();

        // contention after reset: m0 first, gap cycle, then m1, then m0 again
        do_reset();
        cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1;
        settle(); tick();
        settle(); chk("r30_first", grant, 2'b01);
        s_ack = 1; settle(); tick();
        s_ack = 0; cyc[0] = 0; stb[0] = 0; settle(); tick();
        settle(); chk("r30_gap", grant, 2'b00); tick();
        settle(); chk("r30_second", grant, 2'b10);
        s_ack = 1; settle(); tick();
        s_ack = 0; cyc[1] = 0; stb[1] = 0; settle(); tick();
        cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1;
        settle(); chk("r30_idle", grant, 2'b00); tick();
        settle(); chk("r30_third", grant, 2'b01); tick();
        idle(); settle(); tick(); settle(); tick();

        // m1 holds cyc over three writes while m0 waits
        cyc[1] = 1; stb[1] = 1; we[1] = 1; sel[1] = 4'hF; adr[1] = adrs[0];
        settle(); tick();
        cyc[0] = 1; stb[0] = 1;
        for (int i = 0; i < 3; i++) begin
            adr[1] = adrs[i]; wdat[1] = $urandom; s_ack = 1;
            settle(); chk("r31_beat", {grant, s_bus.we, s_bus.adr}, {2'b10, 1'b1, adrs[i]}); tick();
        end
        cyc[1] = 0; stb[1] = 0; s_ack = 0;
        settle(); tick();
        settle(); chk("r31_gap", grant, 2'b00); tick();
        settle(); chk("r31_m0", grant, 2'b01);
        idle(); settle(); tick(); settle(); tick();

`ifdef WB_ARB_TIMEOUT_EN
        // hung slave: err pulse 8 cycles after stb, then pending m1 wins
        do_reset();
        cyc[0] = 1; stb[0] = 1;
        settle(); tick();
        cyc[1] = 1; stb[1] = 1;
        for (int i = 0; i < TO; i++) begin
            settle(); chk("r32_noerr", m0_bus.err, 1'b0); tick();
        end
        settle(); chk("r32_err", m0_bus.err, 1'b1); tick();
        settle(); chk("r32_drop", {grant, s_bus.cyc, m0_bus.err}, 4'b0); tick();
        settle(); chk("r32_m1", grant, 2'b10);
        idle(); settle(); tick(); settle(); tick();
`else
        // hung slave keeps the grant with no abort
        cyc[0] = 1; stb[0] = 1;
        settle(); tick();
        for (int i = 0; i < 20; i++) begin
            settle(); chk("hang", {grant, m0_bus.err}, 3'b010); tick();
        end
        idle(); settle(); tick(); settle(); tick();
`endif

        // reset while m1 owns the bus with an ack arriving
        cyc[1] = 1; stb[1] = 1;
        settle(); tick();
        rst = 1; s_ack = 1; s_dat = 32'h1234_5678;
        settle(); chk("r33_rst_ack", m1_bus.ack, 1'b0); tick();
        rst = 0;
        settle(); chk("r33_after", {grant, s_bus.cyc, m1_bus.ack}, 4'b0);
        idle(); settle(); tick(); settle(); tick();

        // stray ack while idle
        s_ack = 1; s_dat = $urandom;
        settle(); chk("r34_stray", {m0_bus.ack, m1_bus.ack}, 2'b00); tick();
        idle();

        for (int k = 0; k < 400; k++) begin
            for (int n = 0; n < 2; n++) begin
                cyc[n] = cyc[n] ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
                stb[n] = cyc[n] & ($urandom_range(9) < 7);
                we[n] = 1'($urandom_range(1));
                sel[n] = 4'($urandom);
                adr[n] = $urandom;
                wdat[n] = $urandom;
            end
            s_ack = $urandom_range(9) < 3;
            s_dat = $urandom;
            rst = $urandom_range(99) == 0;
            settle(); tick();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
